// File: rtl/program_loader.sv
// Boot-time program loader: receives a 16-bit word-count header and big-endian
// instruction bytes, writes assembled words to program memory, then releases the core.
module program_loader #(
  parameter int unsigned               MEMORY_DEPTH = 32,
  parameter int unsigned               DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]     BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error,
  output logic [15:0]           WordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_byte_ready;
  logic                  r_mem_write;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_error;
  logic [15:0]           r_word_count;
  logic [15:0]           r_header;
  logic [1:0]            r_byte_idx;
  logic                  w_accept;
  logic [15:0]           w_hdr_count;
  logic                  w_restart;

  always_comb begin
    w_accept    = byte_valid && r_byte_ready;
    w_hdr_count = {r_header[15:8], byte_in};
    w_restart   = 1'b0;
    w_next      = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_next    = S_HDR_HI;
          w_restart = 1'b1;
        end
      end
      S_HDR_HI: if (w_accept) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_hdr_count == 16'd0 || w_hdr_count > 16'(MEMORY_DEPTH))
            w_next = S_ERROR;
          else
            w_next = S_LOAD;
        end
      end
      S_LOAD: if (w_accept && r_byte_idx == 2'd3) w_next = S_WRITE;
      S_WRITE: begin
        if (r_word_count + 16'd1 == r_header) w_next = S_DONE;
        else                                  w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and write strobe are registered from the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= BASE_ADDRESS;
      r_data       <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_header     <= '0;
      r_byte_idx   <= '0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == S_HDR_HI) || (w_next == S_HDR_LO) || (w_next == S_LOAD);
      r_mem_write  <= (w_next == S_WRITE);
      if (w_restart) begin
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_word_count <= '0;
        r_cpu_hold   <= 1'b1;
      end
      case (r_state)
        S_HDR_HI: if (w_accept) r_header[15:8] <= byte_in;
        S_HDR_LO: begin
          if (w_accept) begin
            r_header[7:0] <= byte_in;
            if (w_next == S_ERROR) begin
              r_error <= 1'b1;
            end else begin
              r_addr     <= BASE_ADDRESS;
              r_byte_idx <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_data     <= {r_data[DATA_WIDTH-9:0], byte_in};
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_word_count <= r_word_count + 16'd1;
          if (w_next == S_DONE) begin
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_addr <= r_addr + DATA_WIDTH'(4);
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_ready   = r_byte_ready;
  assign MemWrite     = r_mem_write;
  assign MemAddress   = r_addr;
  assign MemWriteData = r_data;
  assign CpuHold      = r_cpu_hold;
  assign Done         = r_done;
  assign Error        = r_error;
  assign WordCount    = r_word_count;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time controller that fills the writable program memory from a byte stream before the single-cycle core runs. It holds the core in reset, receives a 16-bit word-count header followed by big-endian instruction bytes over a valid/ready handshake, and assembles each group of 4 bytes into a 32-bit word. Each word is written to the program memory at consecutive word-aligned byte addresses starting at BASE_ADDRESS. When loading completes it releases the core.

Parameters:
MEMORY_DEPTH, 32, number of 32-bit words the program memory holds; upper bound on header count
DATA_WIDTH, 32, instruction/address width
BASE_ADDRESS, 32'h0040_0000, byte address of the first instruction written

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a load session
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
MemWrite  output  1  one-cycle program-memory write strobe
MemAddress  output  DATA_WIDTH  byte address of the word being written (bits [1:0] always 0)
MemWriteData  output  DATA_WIDTH  assembled instruction word
CpuHold  output  1  high = core held in reset
Done  output  1  high once every word has been written
Error  output  1  high if the header count is invalid
WordCount  output  16  number of words written in the current session

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low. While reset=0: state IDLE, byte_ready=0, MemWrite=0, MemAddress=BASE_ADDRESS, MemWriteData=0, CpuHold=1, Done=0, Error=0, WordCount=0, internal byte counter and header register = 0.
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a registered output: 1 only in HDR_HI, HDR_LO and LOAD; 0 in every other state.
- State IDLE: waits for start, then goes to HDR_HI. Done, Error and WordCount are cleared on that edge and CpuHold is set to 1.
- State HDR_HI: the accepted byte becomes header[15:8]; next state HDR_LO.
- State HDR_LO: the accepted byte becomes header[7:0].
  - If the resulting count is 0 or greater than MEMORY_DEPTH, go to ERROR.
  - Otherwise go to LOAD with byte index 0 and MemAddress=BASE_ADDRESS.
- State LOAD: bytes shift into MemWriteData big-endian, so the first byte lands in [31:24] and the fourth in [7:0]. On acceptance of the 4th byte, go to WRITE.
- State WRITE: exactly one cycle.
  - MemWrite=1, with MemAddress and MemWriteData stable for that whole cycle.
  - On exit, WordCount increments.
  - If WordCount+1 equals header, go to DONE.
  - Otherwise MemAddress += 4 and return to LOAD.
- Throughput: 5 cycles per word at full rate (4 accepts + 1 write).
- State DONE: Done=1 and CpuHold=0 are registered, so both are asserted in the first cycle after the final write cycle. MemWrite=0. A new start re-enters HDR_HI with CpuHold=1 (reload).
- State ERROR: Error=1, CpuHold stays 1, no memory writes. Only start leaves this state (goes to HDR_HI with Error cleared).
- start outside IDLE/DONE/ERROR is ignored. A mid-load start does not restart the session.
- Stalls: byte_valid may drop at any time. The loader waits indefinitely with byte_ready=1 and all state preserved.
- MemAddress arithmetic: DATA_WIDTH-bit, wraps modulo 2^DATA_WIDTH. It never exceeds BASE_ADDRESS + 4*(MEMORY_DEPTH-1) because the header is bounded.
- Reset mid-session: asynchronous return to reset values regardless of state. A write in progress is aborted (MemWrite drops immediately).

Test Plan:
- Basic load:
  - Stimulus: reset, start; stream 00 02, then DE AD BE EF, then 20 08 00 05.
  - Required: two MemWrite pulses with (0x00400000, 0xDEADBEEF) and (0x00400004, 0x20080005).
  - Then Done=1, CpuHold=0, WordCount=2.
- Backpressure gaps:
  - Stimulus: same stream as the basic load, with byte_valid low 3 cycles between every byte.
  - Required: identical writes and data, no duplicate or lost bytes, byte_ready held 1 during gaps.
- Invalid headers:
  - Stimulus: header 00 00, then separately header 00 21 (33 > MEMORY_DEPTH=32).
  - Required: Error=1, CpuHold=1, zero MemWrite pulses, byte_ready=0.
  - Then start with header 00 01 plus 4 bytes: Error clears and 1 word is written.
- Full-depth load:
  - Stimulus: header 00 20 with 32 words of pattern 0x000000NN.
  - Required: last write at address 0x0040007C; Done asserts after the 32nd write; WordCount=32.
- Reset mid-load:
  - Stimulus: drop reset during the second word's LOAD.
  - Required: all outputs return to reset values asynchronously; a subsequent start with a 1-word header writes at 0x00400000.
- Reload after Done:
  - Stimulus: start again after a completed session.
  - Required: CpuHold returns to 1 the next cycle and Done clears; start pulses issued during LOAD have no effect.
